// File: rtl/counter_sequencer.sv
// Command-side sequencer for parameterized_counter: drives load / count-up / count-down
// phases and checks the returned count against an internally tracked expected value.
module counter_sequencer #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] init_val_i,
    input  logic [CYC_W-1:0] up_cycles_i,
    input  logic [CYC_W-1:0] down_cycles_i,
    input  logic [WIDTH-1:0] count_in_i,
    output logic             ctr_reset_o,
    output logic             ctr_up_o,
    output logic             ctr_down_o,
    output logic [WIDTH-1:0] ctr_init_val_o,
    output logic [WIDTH-1:0] exp_count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, FIN} state_e;

    state_e           state_q, state_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] up_q, up_d;
    logic [CYC_W-1:0] down_q, down_d;
    logic [WIDTH-1:0] init_q, init_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             error_q, error_d;
    logic             ctr_reset_q, ctr_reset_d;
    logic             ctr_up_q, ctr_up_d;
    logic             ctr_down_q, ctr_down_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            up_q        <= '0;
            down_q      <= '0;
            init_q      <= '0;
            exp_q       <= '0;
            error_q     <= 1'b0;
            ctr_reset_q <= 1'b0;
            ctr_up_q    <= 1'b0;
            ctr_down_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            up_q        <= up_d;
            down_q      <= down_d;
            init_q      <= init_d;
            exp_q       <= exp_d;
            error_q     <= error_d;
            ctr_reset_q <= ctr_reset_d;
            ctr_up_q    <= ctr_up_d;
            ctr_down_q  <= ctr_down_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // cnt_q holds the cycles remaining in the current UP/DOWN phase, including this one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) state_d = LOAD;
            end
            LOAD: begin
                if (up_q != '0) begin
                    state_d = UP;
                    cnt_d   = up_q;
                end else if (down_q != '0) begin
                    state_d = DOWN;
                    cnt_d   = down_q;
                end else begin
                    state_d = FIN;
                end
            end
            UP: begin
                if (cnt_q == CYC_W'(1)) begin
                    if (down_q != '0) begin
                        state_d = DOWN;
                        cnt_d   = down_q;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            DOWN: begin
                if (cnt_q == CYC_W'(1)) state_d = FIN;
                else                    cnt_d   = cnt_q - CYC_W'(1);
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i && state_q != IDLE) state_d = IDLE;
    end

    // Drives are registered from the next state so they line up with the state they belong to.
    always_comb begin
        ctr_reset_d = (state_d == LOAD);
        ctr_up_d    = (state_d == UP);
        ctr_down_d  = (state_d == DOWN);
        done_d      = (state_d == FIN);
        busy_d      = (state_d != IDLE);
    end

    // Expected count follows the current phase even on an aborting edge.
    always_comb begin
        init_d  = init_q;
        up_d    = up_q;
        down_d  = down_q;
        exp_d   = exp_q;
        error_d = error_q;
        if (state_q == IDLE && state_d == LOAD) begin
            init_d  = init_val_i;
            up_d    = up_cycles_i;
            down_d  = down_cycles_i;
            error_d = 1'b0;
        end
        case (state_q)
            LOAD:    exp_d = init_q;
            UP:      exp_d = exp_q + WIDTH'(1);
            DOWN:    exp_d = exp_q - WIDTH'(1);
            default: exp_d = exp_q;
        endcase
        if ((state_q == UP || state_q == DOWN || state_q == FIN) && count_in_i != exp_q)
            error_d = 1'b1;
    end

    assign ctr_reset_o    = ctr_reset_q;
    assign ctr_up_o       = ctr_up_q;
    assign ctr_down_o     = ctr_down_q;
    assign ctr_init_val_o = init_q;
    assign exp_count_o    = exp_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;

endmodule
